// File: rtl/jk_bank_arbiter_if.sv
// Two-requester command/handshake bundle for the JK bank arbiter.
interface jk_bank_arbiter_if #(
    parameter int unsigned AW = 3
);
    logic          req0_valid;
    logic [AW-1:0] req0_addr;
    logic [1:0]    req0_op;
    logic          req0_ready;
    logic          req1_valid;
    logic [AW-1:0] req1_addr;
    logic [1:0]    req1_op;
    logic          req1_ready;

    modport master (
        output req0_valid, req0_addr, req0_op,
        output req1_valid, req1_addr, req1_op,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_addr, req0_op,
        input  req1_valid, req1_addr, req1_op,
        output req0_ready, req1_ready
    );
endinterface

// File: rtl/jk_bank_arbiter.sv
// Bank of N JK bits shared by two requesters; round-robin grant, then a
// fixed IDLE -> APPLY -> DONE sequence per command.
module jk_bank_arbiter #(
    parameter int unsigned N  = 8,
    parameter int unsigned AW = 3
) (
    input  logic                clk,
    input  logic                reset,
    jk_bank_arbiter_if.slave    req,
    output logic [N-1:0]        q,
    output logic [N-1:0]        q_bar,
    output logic                busy,
    output logic                err,
    output logic                last_grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          id_q, id_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [1:0]    op_q, op_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  q_bar_q, q_bar_d;
    logic          ready0_q, ready0_d;
    logic          ready1_q, ready1_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic          last_grant_q, last_grant_d;

    logic          in_range_c;
    logic [N-1:0]  sel_c;

    // Out-of-range addresses select no bit, so APPLY leaves the bank untouched.
    assign in_range_c = (32'(addr_q) < N);
    assign sel_c      = in_range_c ? (N'(1) << addr_q) : '0;

    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        addr_d       = addr_q;
        op_d         = op_q;
        q_d          = q_q;
        last_grant_d = last_grant_q;
        ready0_d     = 1'b0;
        ready1_d     = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (req.req0_valid || req.req1_valid) begin
                    // On a tie the requester that was not granted last wins.
                    if (req.req0_valid && req.req1_valid) id_d = ~last_grant_q;
                    else                                  id_d = req.req1_valid;
                    addr_d       = id_d ? req.req1_addr : req.req0_addr;
                    op_d         = id_d ? req.req1_op   : req.req0_op;
                    last_grant_d = id_d;
                    state_d      = APPLY;
                end
            end
            APPLY: begin
                case (op_q)
                    2'b01:   q_d = q_q & ~sel_c;
                    2'b10:   q_d = q_q | sel_c;
                    2'b11:   q_d = q_q ^ sel_c;
                    default: q_d = q_q;
                endcase
                state_d = DONE;
            end
            DONE: begin
                ready0_d = ~id_q;
                ready1_d = id_q;
                err_d    = ~in_range_c;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        q_bar_d = ~q_d;
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            id_q         <= 1'b0;
            addr_q       <= '0;
            op_q         <= 2'b00;
            q_q          <= '0;
            q_bar_q      <= '1;
            ready0_q     <= 1'b0;
            ready1_q     <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            addr_q       <= addr_d;
            op_q         <= op_d;
            q_q          <= q_d;
            q_bar_q      <= q_bar_d;
            ready0_q     <= ready0_d;
            ready1_q     <= ready1_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign q              = q_q;
    assign q_bar          = q_bar_q;
    assign busy           = busy_q;
    assign err            = err_q;
    assign last_grant     = last_grant_q;
    assign req.req0_ready = ready0_q;
    assign req.req1_ready = ready1_q;

endmodule
